// File: rtl/neuron_mac_datapath.sv
// Purpose : MLP arithmetic stage. It multiplies neuron by weight RAM data, accumulates each output
//           neuron, then rounds, saturates and writes the result back to the neuron RAM.
// Latency : a ctl beat at cycle t with ctl_last produces wr_en in cycle t+MEM_LAT+2, one cycle wide.
// Backpressure: none. The stage accepts one beat per cycle, and bubbles (ctl_valid=0) hold all state.
// Ports   : clk/reset_n (async active-low); ctl_* are per-weight control beats whose RAM addresses
//           are issued in the same cycle; neuron_data/weight_data return MEM_LAT cycles later;
//           wr_en/wr_addr/wr_data form the neuron write port; busy, seq_err (sticky) and mlp_done are status.
// Config  : define MAC_RELU_EN to write negative saturated results as zero (ReLU on every layer).
module neuron_mac_datapath #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40,
    parameter int ADDR_W    = 12,
    parameter int MEM_LAT   = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ctl_valid,
    input  logic                     ctl_first,
    input  logic                     ctl_last,
    input  logic [ADDR_W-1:0]        ctl_addr,
    input  logic                     ctl_done,
    input  logic signed [DATA_W-1:0] neuron_data,
    input  logic signed [DATA_W-1:0] weight_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     busy,
    output logic                     seq_err,
    output logic                     mlp_done
);

    typedef struct packed {
        logic              vld;
        logic              first;
        logic              last;
        logic [ADDR_W-1:0] addr;
    } beat_t;

    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] MAX_C = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MIN_C = -(ACC_W'(1) << (DATA_W - 1));

    // Beat tags ride alongside the RAM read, so the tail of this line lines up with the returning data.
    beat_t dl_q [MEM_LAT];
    beat_t aligned;
    logic  dl_any_vld;

    // Stage P registers.
    logic                     p_vld_q, p_first_q, p_last_q;
    logic [ADDR_W-1:0]        p_addr_q;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [PROD_W-1:0] prod_d;

    // Stage A state.
    logic signed [ACC_W-1:0]  acc_q, acc_base, acc_next, rnd_sum, rnd;
    logic                     open_q, open_d;
    logic                     seq_err_q, seq_err_d;
    logic [DATA_W-1:0]        sat_val, res_val;
    logic                     wr_en_q;
    logic [ADDR_W-1:0]        wr_addr_q;
    logic [DATA_W-1:0]        wr_data_q;
    logic                     mlp_done_q;

    assign aligned = dl_q[MEM_LAT-1];
    assign prod_d  = neuron_data * weight_data;

    always_comb begin
        dl_any_vld = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            dl_any_vld = dl_any_vld | dl_q[i].vld;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= '{vld: ctl_valid, first: ctl_first, last: ctl_last, addr: ctl_addr};
            for (int i = 1; i < MEM_LAT; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_vld_q   <= 1'b0;
            p_first_q <= 1'b0;
            p_last_q  <= 1'b0;
            p_addr_q  <= '0;
            prod_q    <= '0;
        end else begin
            p_vld_q <= aligned.vld;
            if (aligned.vld) begin
                p_first_q <= aligned.first;
                p_last_q  <= aligned.last;
                p_addr_q  <= aligned.addr;
                prod_q    <= prod_d;
            end
        end
    end

    // Accumulate, round half-up on the dropped fraction, then clamp to the signed DATA_W range.
    always_comb begin
        acc_base = p_first_q ? '0 : acc_q;
        acc_next = acc_base + {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
        rnd_sum  = acc_next + RND_C;
        rnd      = rnd_sum >>> FRAC_BITS;
        if (rnd > MAX_C) begin
            sat_val = MAX_C[DATA_W-1:0];
        end else if (rnd < MIN_C) begin
            sat_val = MIN_C[DATA_W-1:0];
        end else begin
            sat_val = rnd[DATA_W-1:0];
        end
`ifdef MAC_RELU_EN
        res_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
        res_val = sat_val;
`endif
    end

    // A protocol error is flagged, but the beat is still accumulated as written.
    always_comb begin
        open_d    = open_q;
        seq_err_d = seq_err_q;
        if (p_vld_q) begin
            if (p_first_q && open_q)   seq_err_d = 1'b1;
            if (!p_first_q && !open_q) seq_err_d = 1'b1;
            if (p_last_q)              open_d = 1'b0;
            else if (p_first_q)        open_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            open_q     <= 1'b0;
            seq_err_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            mlp_done_q <= 1'b0;
        end else begin
            if (p_vld_q) begin
                acc_q <= acc_next;
            end
            open_q    <= open_d;
            seq_err_q <= seq_err_d;
            wr_en_q   <= p_vld_q & p_last_q;
            if (p_vld_q && p_last_q) begin
                wr_addr_q <= p_addr_q;
                wr_data_q <= res_val;
            end
            // A beat issued this cycle is not yet in the delay line, so it also blocks completion.
            if (ctl_done && !ctl_valid && !busy && !wr_en_q) begin
                mlp_done_q <= 1'b1;
            end
        end
    end

    assign busy     = dl_any_vld | p_vld_q | open_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign seq_err  = seq_err_q;
    assign mlp_done = mlp_done_q;

endmodule

// File: tb/tb_neuron_mac_datapath.sv
// Purpose : directed testbench for neuron_mac_datapath, instantiated once with MEM_LAT=1 and once with MEM_LAT=3.
// Latency : the expected write cycle is the last beat's cycle + MEM_LAT + 2.
// Backpressure: none. Stimulus advances one control beat per clock.
module tb_neuron_mac_datapath;
    localparam int DW = 16;
    localparam int AW = 12;
`ifdef MAC_RELU_EN
    localparam logic [DW-1:0] NEG_EXP = 16'h0000;
`else
    localparam logic [DW-1:0] NEG_EXP = 16'h8000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, ctl_valid, ctl_first, ctl_last, ctl_done;
    logic [AW-1:0] ctl_addr;
    logic [DW-1:0] n_in, w_in;
    logic [DW-1:0] nd1, wd1;
    logic [DW-1:0] sr_n3 [3];
    logic [DW-1:0] sr_w3 [3];

    logic          wr_en1, busy1, seq_err1, done1;
    logic [AW-1:0] wr_addr1;
    logic [DW-1:0] wr_data1;
    logic          wr_en3, busy3, seq_err3, done3;
    logic [AW-1:0] wr_addr3;
    logic [DW-1:0] wr_data3;

    // RAM read models: return the beat's operands MEM_LAT cycles later.
    always @(posedge clk) begin
        nd1      <= n_in;
        wd1      <= w_in;
        sr_n3[0] <= n_in;
        sr_n3[1] <= sr_n3[0];
        sr_n3[2] <= sr_n3[1];
        sr_w3[0] <= w_in;
        sr_w3[1] <= sr_w3[0];
        sr_w3[2] <= sr_w3[1];
    end

    neuron_mac_datapath #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ctl_valid(ctl_valid), .ctl_first(ctl_first),
        .ctl_last(ctl_last), .ctl_addr(ctl_addr), .ctl_done(ctl_done),
        .neuron_data(nd1), .weight_data(wd1), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .busy(busy1), .seq_err(seq_err1), .mlp_done(done1)
    );

    neuron_mac_datapath #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .ctl_valid(ctl_valid), .ctl_first(ctl_first),
        .ctl_last(ctl_last), .ctl_addr(ctl_addr), .ctl_done(ctl_done),
        .neuron_data(sr_n3[2]), .weight_data(sr_w3[2]), .wr_en(wr_en3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .busy(busy3), .seq_err(seq_err3), .mlp_done(done3)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wq_a1[$], wq_d1[$], wq_c1[$];
    int wq_a3[$], wq_d3[$], wq_c3[$];
    int done_cyc1 = -1;
    int done_cyc3 = -1;
    int last_cyc  = 0;
    int n_checks  = 0;
    int n_fail    = 0;

    always @(negedge clk) begin
        if (wr_en1) begin
            wq_a1.push_back(int'(wr_addr1));
            wq_d1.push_back(int'(wr_data1));
            wq_c1.push_back(cyc);
        end
        if (wr_en3) begin
            wq_a3.push_back(int'(wr_addr3));
            wq_d3.push_back(int'(wr_data3));
            wq_c3.push_back(cyc);
        end
        if (done1 && done_cyc1 < 0) done_cyc1 = cyc;
        if (done3 && done_cyc3 < 0) done_cyc3 = cyc;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic v, input logic f, input logic l, input logic [AW-1:0] a,
                        input logic [DW-1:0] n, input logic [DW-1:0] w);
        ctl_valid = v;
        ctl_first = f;
        ctl_last  = l;
        ctl_addr  = a;
        n_in      = n;
        w_in      = w;
        if (v && l) last_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        repeat (k) beat(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic clear_q();
        wq_a1.delete(); wq_d1.delete(); wq_c1.delete();
        wq_a3.delete(); wq_d3.delete(); wq_c3.delete();
    endtask

    task automatic chk_quiet(input string tag);
        check_eq({tag, "_wr_en1"}, wr_en1, 0);
        check_eq({tag, "_wr_addr1"}, wr_addr1, 0);
        check_eq({tag, "_wr_data1"}, wr_data1, 0);
        check_eq({tag, "_busy1"}, busy1, 0);
        check_eq({tag, "_seq_err1"}, seq_err1, 0);
        check_eq({tag, "_done1"}, done1, 0);
        check_eq({tag, "_wr_en3"}, wr_en3, 0);
        check_eq({tag, "_busy3"}, busy3, 0);
        check_eq({tag, "_seq_err3"}, seq_err3, 0);
        check_eq({tag, "_done3"}, done3, 0);
    endtask

    // Drain the pipeline and expect exactly one write per instance, at the correct cycle.
    task automatic expect_one(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle(12);
        check_eq({tag, "_cnt1"}, wq_c1.size(), 1);
        if (wq_c1.size() > 0) begin
            check_eq({tag, "_addr1"}, wq_a1[0], a);
            check_eq({tag, "_data1"}, wq_d1[0], d);
            check_eq({tag, "_lat1"}, wq_c1[0] - last_cyc, 3);
        end
        check_eq({tag, "_cnt3"}, wq_c3.size(), 1);
        if (wq_c3.size() > 0) begin
            check_eq({tag, "_addr3"}, wq_a3[0], a);
            check_eq({tag, "_data3"}, wq_d3[0], d);
            check_eq({tag, "_lat3"}, wq_c3[0] - last_cyc, 5);
        end
        clear_q();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        chk_quiet("rst");
        reset_n = 1'b1;
        idle(1);
    endtask

    initial begin
        reset_n = 1'b0;
        ctl_done = 1'b0;
        ctl_valid = 1'b0; ctl_first = 1'b0; ctl_last = 1'b0; ctl_addr = '0;
        n_in = '0; w_in = '0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset_n = 1'b1;
        idle(2);
        chk_quiet("post_reset");

        // Three terms of 1.0*2.0 give 6.0.
        beat(1, 1, 0, 12'h805, 16'h0100, 16'h0200);
        beat(1, 0, 0, 12'h805, 16'h0100, 16'h0200);
        beat(1, 0, 1, 12'h805, 16'h0100, 16'h0200);
        expect_one("mac3", 12'h805, 16'h0600);

        // Positive overflow saturates to the maximum value.
        beat(1, 1, 0, 12'h010, 16'h7FFF, 16'h7FFF);
        beat(1, 0, 0, 12'h010, 16'h7FFF, 16'h7FFF);
        beat(1, 0, 0, 12'h010, 16'h7FFF, 16'h7FFF);
        beat(1, 0, 1, 12'h010, 16'h7FFF, 16'h7FFF);
        expect_one("satpos", 12'h010, 16'h7FFF);

        // Negative overflow clamps to -2^15, or to zero when ReLU is enabled.
        beat(1, 1, 0, 12'h011, 16'h8000, 16'h7FFF);
        beat(1, 0, 0, 12'h011, 16'h8000, 16'h7FFF);
        beat(1, 0, 0, 12'h011, 16'h8000, 16'h7FFF);
        beat(1, 0, 1, 12'h011, 16'h8000, 16'h7FFF);
        expect_one("satneg", 12'h011, NEG_EXP);

        // Single-term neuron: 1.5*1.5 = 2.25.
        beat(1, 1, 1, 12'h003, 16'h0180, 16'h0180);
        expect_one("single", 12'h003, 16'h0240);

        // Bubbles between the terms of one neuron.
        beat(1, 1, 0, 12'h022, 16'h0100, 16'h0200);
        idle(2);
        beat(1, 0, 0, 12'h022, 16'h0100, 16'h0200);
        idle(1);
        beat(1, 0, 1, 12'h022, 16'h0100, 16'h0200);
        expect_one("bubble", 12'h022, 16'h0600);

        // Two neurons back to back: 2*(1*1)=2.0, then a fresh 2*3=6.0.
        beat(1, 1, 0, 12'h001, 16'h0100, 16'h0100);
        beat(1, 0, 1, 12'h001, 16'h0100, 16'h0100);
        beat(1, 1, 1, 12'h002, 16'h0200, 16'h0300);
        idle(12);
        check_eq("b2b_cnt1", wq_c1.size(), 2);
        if (wq_c1.size() == 2) begin
            check_eq("b2b_addr1a", wq_a1[0], 1);
            check_eq("b2b_data1a", wq_d1[0], 16'h0200);
            check_eq("b2b_addr1b", wq_a1[1], 2);
            check_eq("b2b_data1b", wq_d1[1], 16'h0600);
            check_eq("b2b_gap1", wq_c1[1] - wq_c1[0], 1);
            check_eq("b2b_lat1", wq_c1[1] - last_cyc, 3);
        end
        check_eq("b2b_cnt3", wq_c3.size(), 2);
        if (wq_c3.size() == 2) begin
            check_eq("b2b_data3b", wq_d3[1], 16'h0600);
            check_eq("b2b_gap3", wq_c3[1] - wq_c3[0], 1);
        end
        clear_q();
        check_eq("clean_seq_err1", seq_err1, 0);
        check_eq("clean_seq_err3", seq_err3, 0);
        check_eq("idle_busy1", busy1, 0);
        check_eq("idle_done1", done1, 0);

        // ctl_done raised while the last beat is still in flight.
        ctl_done = 1'b1;
        beat(1, 1, 1, 12'h007, 16'h0100, 16'h0100);
        idle(12);
        check_eq("done_cnt1", wq_c1.size(), 1);
        check_eq("done_cnt3", wq_c3.size(), 1);
        if (wq_c1.size() > 0) begin
            check_eq("done_data1", wq_d1[0], 16'h0100);
            check_eq("done_after_wr1", done_cyc1 > wq_c1[0], 1);
            check_eq("done_prompt1", done_cyc1 <= wq_c1[0] + 2, 1);
        end
        if (wq_c3.size() > 0) begin
            check_eq("done_after_wr3", done_cyc3 > wq_c3[0], 1);
            check_eq("done_prompt3", done_cyc3 <= wq_c3[0] + 2, 1);
        end
        check_eq("done_level1", done1, 1);
        check_eq("done_level3", done3, 1);
        clear_q();
        ctl_done = 1'b0;
        do_reset();

        // A middle beat straight after reset is a protocol error.
        beat(1, 0, 0, 12'h009, 16'h0100, 16'h0100);
        idle(8);
        check_eq("mid_seq_err1", seq_err1, 1);
        check_eq("mid_seq_err3", seq_err3, 1);
        idle(5);
        check_eq("mid_sticky1", seq_err1, 1);
        check_eq("mid_nowr1", wq_c1.size(), 0);
        clear_q();
        do_reset();

        // A first beat while a neuron is open is an error; the second first restarts the sum.
        beat(1, 1, 0, 12'h00A, 16'h0300, 16'h0300);
        beat(1, 1, 0, 12'h00A, 16'h0100, 16'h0200);
        beat(1, 0, 1, 12'h00A, 16'h0100, 16'h0200);
        expect_one("reopen", 12'h00A, 16'h0400);
        check_eq("reopen_seq_err1", seq_err1, 1);
        check_eq("reopen_seq_err3", seq_err3, 1);
        do_reset();

        // Reset in the middle of a neuron discards it.
        beat(1, 1, 0, 12'h044, 16'h0100, 16'h0100);
        beat(1, 0, 0, 12'h044, 16'h0100, 16'h0100);
        reset_n = 1'b0;
        beat(1, 0, 1, 12'h044, 16'h0100, 16'h0100);
        idle(1);
        chk_quiet("midrst");
        reset_n = 1'b1;
        idle(12);
        check_eq("midrst_nowr1", wq_c1.size(), 0);
        check_eq("midrst_nowr3", wq_c3.size(), 0);
        check_eq("midrst_busy1", busy1, 0);
        check_eq("midrst_seq_err1", seq_err1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
